// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Builds MIPS32 instruction words from field-level requests (SPECIAL, SPECIAL2
// and I-type subsets), queues them in a small FIFO and streams them out over a
// valid/ready handshake. Fields the ID stage ignores are forced to zero so that
// every emitted word is the canonical encoding. Illegal requests are accepted,
// dropped, and recorded in a sticky error flag.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 2)
//   LW         width of level_o, log2(DEPTH)+1
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted when req_valid & req_ready (FIFO not full)
//   req_class  0 SPECIAL, 1 SPECIAL2, 2 I-type, 3 illegal
//   req_fn     funct (class 0/1) or opcode (class 2)
//   req_rs     rs field
//   req_rt     rt field
//   req_rd     rd field
//   req_shamt  shift amount (also SYNC stype)
//   req_imm    16-bit immediate / offset
//   inst_valid FIFO non-empty
//   inst_o     registered head-of-FIFO instruction word (0 when empty)
//   inst_ready consumer pops when inst_valid & inst_ready
//   err_o      sticky illegal-request flag
//   err_clr    clears err_o (an illegal accept in the same cycle wins)
//   level_o    FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module inst_encoder #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_class,
    input  logic [5:0]    req_fn,
    input  logic [4:0]    req_rs,
    input  logic [4:0]    req_rt,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_shamt,
    input  logic [15:0]   req_imm,
    output logic          inst_valid,
    output logic [31:0]   inst_o,
    input  logic          inst_ready,
    output logic          err_o,
    input  logic          err_clr,
    output logic [LW-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    // Encoder outputs
    logic          legal_s;
    logic          itype_s;
    logic [5:0]    op_s;
    logic [4:0]    rs_s;
    logic [4:0]    rt_s;
    logic [4:0]    rd_s;
    logic [4:0]    sh_s;
    logic [31:0]   word_s;

    // Handshake strobes
    logic          accept_s;
    logic          push_s;
    logic          illegal_s;
    logic          pop_s;

    // FIFO state
    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          valid_r;
    logic [31:0]   head_r;
    logic          err_r;

    // Next-state values
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [LW-1:0] level_nxt_s;
    logic          valid_nxt_s;
    logic [31:0]   head_nxt_s;
    logic          err_nxt_s;
    logic [AW-1:0] rd_ptr_inc_s;

    // Field-level legality check and canonical zeroing, then word assembly
    always_comb begin
        legal_s = 1'b0;
        itype_s = 1'b0;
        op_s    = OP_SPECIAL;
        rs_s    = req_rs;
        rt_s    = req_rt;
        rd_s    = req_rd;
        sh_s    = req_shamt;
        case (req_class)
            2'd0: begin
                op_s = OP_SPECIAL;
                case (req_fn)
                    // SLL / SRL / SRA: shift by immediate, rs unused
                    6'h00, 6'h02, 6'h03: begin
                        legal_s = 1'b1;
                        rs_s    = 5'd0;
                    end
                    // Variable shifts, MOVZ/MOVN and three-register ALU ops
                    6'h04, 6'h06, 6'h07, 6'h0A, 6'h0B,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        legal_s = 1'b1;
                        sh_s    = 5'd0;
                    end
                    // SYNC: only the stype (shamt) field carries meaning
                    6'h0F: begin
                        legal_s = 1'b1;
                        rs_s    = 5'd0;
                        rt_s    = 5'd0;
                        rd_s    = 5'd0;
                    end
                    // MFHI / MFLO: destination only
                    6'h10, 6'h12: begin
                        legal_s = 1'b1;
                        rs_s    = 5'd0;
                        rt_s    = 5'd0;
                        sh_s    = 5'd0;
                    end
                    // MTHI / MTLO: source only
                    6'h11, 6'h13: begin
                        legal_s = 1'b1;
                        rt_s    = 5'd0;
                        rd_s    = 5'd0;
                        sh_s    = 5'd0;
                    end
                    // MULT / MULTU: write HI/LO, no rd
                    6'h18, 6'h19: begin
                        legal_s = 1'b1;
                        rd_s    = 5'd0;
                        sh_s    = 5'd0;
                    end
                    default: begin
                        legal_s = 1'b0;
                    end
                endcase
            end
            2'd1: begin
                op_s = OP_SPECIAL2;
                case (req_fn)
                    // MADD / MADDU / MSUB / MSUBU: accumulate into HI/LO
                    6'h00, 6'h01, 6'h04, 6'h05: begin
                        legal_s = 1'b1;
                        rd_s    = 5'd0;
                        sh_s    = 5'd0;
                    end
                    // MUL: three-register form
                    6'h02: begin
                        legal_s = 1'b1;
                        sh_s    = 5'd0;
                    end
                    // CLZ / CLO: architecture requires rt to equal rd
                    6'h20, 6'h21: begin
                        legal_s = 1'b1;
                        rt_s    = req_rd;
                        sh_s    = 5'd0;
                    end
                    default: begin
                        legal_s = 1'b0;
                    end
                endcase
            end
            2'd2: begin
                op_s    = req_fn;
                itype_s = 1'b1;
                case (req_fn)
                    6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h33: begin
                        legal_s = 1'b1;
                    end
                    // LUI has no source register
                    6'h0F: begin
                        legal_s = 1'b1;
                        rs_s    = 5'd0;
                    end
                    default: begin
                        legal_s = 1'b0;
                    end
                endcase
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase

        if (itype_s) begin
            word_s = {op_s, rs_s, rt_s, req_imm};
        end else begin
            word_s = {op_s, rs_s, rt_s, rd_s, sh_s, req_fn};
        end
    end

    // Ready comes straight from registered occupancy, so a same-cycle pop never
    // opens a slot for a request while full.
    assign req_ready = (level_r != LW'(DEPTH));
    assign accept_s  = req_valid & req_ready;
    assign push_s    = accept_s & legal_s;
    assign illegal_s = accept_s & ~legal_s;
    assign pop_s     = valid_r & inst_ready;

    assign rd_ptr_inc_s = rd_ptr_r + AW'(1);

    // Next-state computation for pointers, occupancy, head register and error flag
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        level_nxt_s  = level_r;
        head_nxt_s   = head_r;
        err_nxt_s    = err_r;

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_inc_s;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase

        // The head register mirrors mem[rd_ptr]. On a pop it takes the next
        // stored entry; if the FIFO is draining its last entry it takes the
        // word being pushed this cycle (bypass), or zero when nothing arrives.
        if (pop_s) begin
            if (level_r > LW'(1)) begin
                head_nxt_s = mem_r[rd_ptr_inc_s];
            end else if (push_s) begin
                head_nxt_s = word_s;
            end else begin
                head_nxt_s = 32'd0;
            end
        end else if (level_r == LW'(0)) begin
            if (push_s) begin
                head_nxt_s = word_s;
            end else begin
                head_nxt_s = 32'd0;
            end
        end else begin
            head_nxt_s = head_r;
        end

        // Setting takes priority over clearing
        if (illegal_s) begin
            err_nxt_s = 1'b1;
        end else if (err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end

        valid_nxt_s = (level_nxt_s != LW'(0));
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            valid_r  <= 1'b0;
            head_r   <= 32'd0;
            err_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            valid_r  <= valid_nxt_s;
            head_r   <= head_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    // FIFO storage; contents are only ever read behind valid pointers, so no reset
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    assign inst_valid = valid_r;
    assign inst_o     = head_r;
    assign err_o      = err_r;
    assign level_o    = level_r;

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
//
// Scoreboard bench for inst_encoder. A driver issues requests and pushes the
// reference-model word into exp_q at each accepting edge; a monitor, running
// independently, compares the DUT head/occupancy/flags against the scoreboard
// every cycle and pops on each consumer handshake.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_class;
    logic [5:0]    req_fn;
    logic [4:0]    req_rs;
    logic [4:0]    req_rt;
    logic [4:0]    req_rd;
    logic [4:0]    req_shamt;
    logic [15:0]   req_imm;
    logic          inst_valid;
    logic [31:0]   inst_o;
    logic          inst_ready;
    logic          err_o;
    logic          err_clr;
    logic [LW-1:0] level_o;

    inst_encoder #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_class  (req_class),
        .req_fn     (req_fn),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_shamt  (req_shamt),
        .req_imm    (req_imm),
        .inst_valid (inst_valid),
        .inst_o     (inst_o),
        .inst_ready (inst_ready),
        .err_o      (err_o),
        .err_clr    (err_clr),
        .level_o    (level_o)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    bit          model_err = 1'b0;
    bit          mon_en    = 1'b0;
    int          pop_pct   = 0;
    int          cmp_cnt   = 0;
    int          bad_cnt   = 0;

    int c0_tab[25] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h0F, 'h10, 'h11,
                       'h12, 'h13, 'h18, 'h19, 'h0A, 'h0B, 'h20, 'h21, 'h22,
                       'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
    int c1_tab[7]  = '{'h00, 'h01, 'h02, 'h04, 'h05, 'h20, 'h21};
    int c2_tab[9]  = '{'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F, 'h33};

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder: instruction semantics from the ISA field rules, word
    // assembled by positional arithmetic.
    function automatic void ref_encode(input int cls, input int fn, input int rs,
                                       input int rt, input int rd, input int sh,
                                       input int imm, output bit legal,
                                       output logic [31:0] w);
        int     op;
        bit     itype;
        longint acc;
        legal = 1'b1;
        itype = 1'b0;
        op    = 0;
        case (cls)
            0: begin
                op = 0;
                if (fn inside {'h00, 'h02, 'h03}) rs = 0;
                else if (fn inside {'h04, 'h06, 'h07, 'h0A, 'h0B, ['h20:'h27], 'h2A, 'h2B}) sh = 0;
                else if (fn == 'h0F) begin rs = 0; rt = 0; rd = 0; end
                else if (fn inside {'h10, 'h12}) begin rs = 0; rt = 0; sh = 0; end
                else if (fn inside {'h11, 'h13}) begin rt = 0; rd = 0; sh = 0; end
                else if (fn inside {'h18, 'h19}) begin rd = 0; sh = 0; end
                else legal = 1'b0;
            end
            1: begin
                op = 'h1C;
                if (fn inside {'h00, 'h01, 'h04, 'h05}) begin rd = 0; sh = 0; end
                else if (fn == 'h02) sh = 0;
                else if (fn inside {'h20, 'h21}) begin rt = rd; sh = 0; end
                else legal = 1'b0;
            end
            2: begin
                op    = fn;
                itype = 1'b1;
                if (fn == 'h0F) rs = 0;
                else if (!(fn inside {['h08:'h0E], 'h33})) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (itype) acc = ((longint'(op) * 32 + rs) * 32 + rt) * 65536 + imm;
        else       acc = ((((longint'(op) * 32 + rs) * 32 + rt) * 32 + rd) * 32 + sh) * 64 + fn;
        w = acc[31:0];
    endfunction

    // One clock of stimulus; the scoreboard is updated at the accepting edge.
    task automatic cycle(input bit v, input int c, input int f, input int s, input int t,
                         input int d, input int sh, input int im, input bit clr,
                         input bit use_exp, input logic [31:0] exp_w, output bit accepted);
        bit          legal;
        bit          rdy_m;
        logic [31:0] w;
        @(negedge clk);
        req_valid  = v;
        req_class  = 2'(c);
        req_fn     = 6'(f);
        req_rs     = 5'(s);
        req_rt     = 5'(t);
        req_rd     = 5'(d);
        req_shamt  = 5'(sh);
        req_imm    = 16'(im);
        err_clr    = clr;
        inst_ready = ($urandom_range(0, 99) < pop_pct);
        rdy_m = (exp_q.size() != DEPTH);
        check32("req_ready", 32'(req_ready), 32'(rdy_m));
        ref_encode(c, f, s, t, d, sh, im, legal, w);
        if (use_exp) w = exp_w;
        accepted = v && rdy_m;
        @(posedge clk);
        if (accepted && legal) exp_q.push_back(w);
        if (accepted && !legal) model_err = 1'b1;
        else if (clr) model_err = 1'b0;
    endtask

    task automatic idle(input int n, input bit clr);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, clr, 1'b0, 32'd0, acc);
    endtask

    // Holds a request until accepted, with a cycle budget.
    task automatic send(input int c, input int f, input int s, input int t, input int d,
                        input int sh, input int im, input bit clr, input bit use_exp,
                        input logic [31:0] exp_w);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 40) begin
            cycle(1'b1, c, f, s, t, d, sh, im, clr, use_exp, exp_w, acc);
            n++;
        end
        if (!acc) begin
            cmp_cnt++;
            bad_cnt++;
            $display("FAIL send_timeout: request class %0d fn %h not accepted after %0d cycles", c, f, n);
        end
    endtask

    task automatic rand_legal(output int c, output int f);
        c = $urandom_range(0, 2);
        case (c)
            0:       f = c0_tab[$urandom_range(0, 24)];
            1:       f = c1_tab[$urandom_range(0, 6)];
            default: f = c2_tab[$urandom_range(0, 8)];
        endcase
    endtask

    task automatic send_rand_legal();
        int c;
        int f;
        rand_legal(c, f);
        send(c, f, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), 1'b0, 1'b0, 32'd0);
    endtask

    // Monitor: checks DUT state against the scoreboard between edges and pops
    // the expected word whenever the consumer handshake will fire.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check32("level_o", 32'(level_o), 32'(exp_q.size()));
                check32("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
                check32("err_o", 32'(err_o), 32'(model_err));
                if (exp_q.size() == 0) begin
                    check32("inst_o_empty", inst_o, 32'd0);
                end else if (rst && inst_ready) begin
                    check32("inst_o_pop", inst_o, exp_q.pop_front());
                end else begin
                    check32("inst_o_held", inst_o, exp_q[0]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Driver
    initial begin
        bit acc;
        int c;
        int f;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_class  = 2'd0;
        req_fn     = 6'd0;
        req_rs     = 5'd0;
        req_rt     = 5'd0;
        req_rd     = 5'd0;
        req_shamt  = 5'd0;
        req_imm    = 16'd0;
        inst_ready = 1'b0;
        err_clr    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Directed encodings with hand-computed words
        pop_pct = 0;
        send(2, 'h0D, 1, 2, 0, 0, 'h1234, 1'b0, 1'b1, 32'h3422_1234); // ORI
        idle(1, 1'b0);
        pop_pct = 100;
        idle(2, 1'b0);
        pop_pct = 0;
        send(0, 'h00, 5, 3, 4, 2, 0, 1'b0, 1'b1, 32'h0003_2080);      // SLL
        send(1, 'h20, 6, 9, 7, 0, 0, 1'b0, 1'b1, 32'h70C7_3820);      // CLZ
        pop_pct = 100;
        idle(3, 1'b0);

        // Fill to full with consumer stalled; fifth request held, then released
        pop_pct = 0;
        for (int i = 0; i < 4; i++) send_rand_legal();
        for (int i = 0; i < 3; i++) cycle(1'b1, 2, 'h09, 3, 4, 0, 0, 'h00FF, 1'b0, 1'b0, 32'd0, acc);
        pop_pct = 100;
        send(2, 'h09, 3, 4, 0, 0, 'h00FF, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) send_rand_legal();
        idle(6, 1'b0);

        // Illegal request, then clear racing an illegal accept, then plain clear
        send(0, 'h01, 1, 2, 3, 4, 0, 1'b0, 1'b0, 32'd0);
        idle(1, 1'b0);
        send(3, 'h20, 1, 2, 3, 4, 0, 1'b1, 1'b0, 32'd0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);

        // Steady push+pop at occupancy 2
        pop_pct = 0;
        send_rand_legal();
        send_rand_legal();
        pop_pct = 100;
        for (int i = 0; i < 12; i++) send_rand_legal();
        idle(4, 1'b0);

        // Randomized traffic
        for (int seg = 0; seg < 4; seg++) begin
            pop_pct = (seg % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    c = $urandom_range(0, 3);
                    f = $urandom_range(0, 63);
                end else begin
                    rand_legal(c, f);
                end
                cycle(($urandom_range(0, 9) < 7), c, f, $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 65535), ($urandom_range(0, 9) == 0), 1'b0, 32'd0, acc);
            end
        end
        pop_pct = 100;
        idle(8, 1'b1);

        // Reset with three entries queued and the error flag set
        pop_pct = 0;
        send(3, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) send_rand_legal();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        err_clr   = 1'b0;
        @(posedge clk);
        exp_q.delete();
        model_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(3, 1'b0);

        pop_pct = 50;
        for (int i = 0; i < 10; i++) send_rand_legal();
        pop_pct = 100;
        idle(8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Assembles MIPS32 instruction words from field-level requests for the subset the ID stage decodes, buffers them in a small FIFO, and streams them out over a valid/ready interface. It sits in front of the instruction ROM loader and the self-checking benches, producing exactly the encodings ID accepts, with unused fields forced to canonical zero. Illegal requests are consumed and dropped, and a sticky error is raised.

## Interface
- DEPTH, 4, output FIFO entries; power of two, at least 2.
- LW, 3, width of `level_o`; equals log2(DEPTH)+1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when `req_valid & req_ready`.
- req_class  in  2  0 = SPECIAL (op 000000), 1 = SPECIAL2 (op 011100), 2 = I-type, 3 = illegal.
- req_fn  in  6  funct for class 0/1; opcode for class 2.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_shamt  in  5  shift amount (SYNC stype).
- req_imm  in  16  immediate/offset.
- inst_valid  out  1  FIFO non-empty.
- inst_o  out  32  head-of-FIFO instruction word.
- inst_ready  in  1  consumer pops when `inst_valid & inst_ready`.
- err_o  out  1  sticky illegal-request flag.
- err_clr  in  1  clears `err_o`.
- level_o  out  LW  FIFO occupancy, 0..DEPTH.

## Operation
- Legal class 0 funct values: 00,02,03,04,06,07,0F,10,11,12,13,18,19,0A,0B,20–27,2A,2B (hex). Class 1: 00,01,02,04,05,20,21. Class 2: 08–0F,33. Anything else, including class 3, is illegal.
- R-type word is {op,rs,rt,rd,shamt,funct}. I-type word is {opcode,rs,rt,imm}.
- Canonical zeroing:
  - SLL/SRL/SRA: rs=0.
  - Other class-0 ALU, variable shifts, MOVN/MOVZ: shamt=0.
  - MFHI/MFLO: rs=rt=shamt=0.
  - MTHI/MTLO: rt=rd=shamt=0.
  - MULT/MULTU/MADD/MADDU/MSUB/MSUBU: rd=shamt=0.
  - SYNC: rs=rt=rd=0, shamt kept.
  - MUL: shamt=0.
  - CLZ/CLO: rt=rd (rt copied from req_rd), shamt=0.
  - LUI: rs=0.
  - PREF: fields passed through.
- Accept: the word is encoded combinationally and written to the FIFO tail on the accept edge.
- Illegal accept: nothing is written, and `err_o` is set on the same edge.
- `req_ready` = `level_o != DEPTH`, driven combinationally from registered occupancy. When full, no request is accepted even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Pop while empty is impossible, because `inst_valid` is 0.
- `err_clr` together with an illegal accept in the same cycle: set wins, so `err_o` stays 1.

## Timing
- Reset (rst=0 at an edge): pointers 0, `level_o`=0, `inst_valid`=0, `inst_o`=0, `err_o`=0, `req_ready`=1 on the cycle after the edge. Reset mid-stream discards all FIFO contents.
- Latency: a legal request accepted at edge N appears on `inst_o` with `inst_valid`=1 after edge N, provided the FIFO was empty.
- Throughput: one request per cycle while not full.
- `inst_o` is the registered head entry and is stable while `inst_valid & !inst_ready`. When empty it holds 0.
- `err_o` becomes 1 the cycle after the illegal accept and clears the cycle after `err_clr`.

## Test plan
- Class 2, fn=0D, rs=1, rt=2, imm=0x1234 (ORI) -> `inst_o`=0x34221234 one cycle later; `level_o`=1.
- Class 0, fn=00, rs=5, rt=3, rd=4, shamt=2 (SLL) -> 0x00032080, with rs forced to 0. Class 1, fn=20, rs=6, rd=7 (CLZ) -> 0x70C73820.
- Push 5 requests with `inst_ready`=0 and DEPTH=4 -> `req_ready`=0 after the 4th; `level_o`=4; the 5th is held. Then pop one with a request pending -> the next push happens one cycle later, and order is preserved across pointer wrap.
- Class 0, fn=01 -> nothing written; `err_o`=1 next cycle. Then `err_clr` with another illegal accept in the same cycle -> `err_o` stays 1.
- Continuous push and pop at `level_o`=2 -> occupancy stays at 2 and words emerge in request order.
- Assert rst=0 with 3 entries queued -> after the edge `inst_valid`=0, `level_o`=0, `inst_o`=0.
